// File: rtl/ofdm_sync_pkg.sv
// Shared types and constants for the OFDM synchronization preamble path.
//   ins_state_t  : preamble inserter FSM states
//   addr_width() : address width of the half-symbol RAM for a given FFT size
//   I_MSB/Q_MSB  : sample packing, I in [31:16], Q in [15:0]
package ofdm_sync_pkg;

   localparam int unsigned I_MSB    = 31;
   localparam int unsigned Q_MSB    = 15;
   localparam int unsigned SAMPLE_W = I_MSB + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CP,
      ST_HALF0,
      ST_HALF1,
      ST_PAYLOAD
   } ins_state_t;

   // Half-symbol RAM address width.
   function automatic int unsigned addr_width(input int unsigned fft_size);
      return $clog2(fft_size / 2);
   endfunction

endpackage

// File: rtl/preamble_ram.sv
// Simple dual-port RAM holding the preamble half-symbol.
//   clk     : clock
//   we_i    : write strobe, waddr_i/wdata_i : write port
//   re_i    : read enable, raddr_i : read address
//   rdata_o : registered read data, holds its value while re_i = 0
// Contents have no reset.
module preamble_ram #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 512,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write port.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Registered read port; doubles as the preamble output register.
   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/schmidl_cox_preamble_inserter.sv
// Prepends a Schmidl-Cox preamble (CP + two identical half-symbols) to each
// tlast-delimited payload frame.
//   clk, reset, clear      : clock, sync active-high reset and soft clear
//   enable                 : insert preamble for the frame about to start
//   cfg_we/addr/data       : half-symbol RAM write port, honoured only in IDLE
//   cfg_busy               : high whenever a frame is in progress
//   i_t*                   : payload input stream
//   o_t*, o_preamble       : framed output stream, o_preamble marks preamble beats
module schmidl_cox_preamble_inserter
   import ofdm_sync_pkg::*;
#(
   parameter  int unsigned FFT_SIZE = 1024,
   parameter  int unsigned CP_SIZE  = 128,
   localparam int unsigned AW       = addr_width(FFT_SIZE)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                enable,
   input  logic                cfg_we,
   input  logic [AW-1:0]       cfg_addr,
   input  logic [SAMPLE_W-1:0] cfg_data,
   output logic                cfg_busy,
   input  logic [SAMPLE_W-1:0] i_tdata,
   input  logic                i_tlast,
   input  logic                i_tvalid,
   output logic                i_tready,
   output logic [SAMPLE_W-1:0] o_tdata,
   output logic                o_tlast,
   output logic                o_tvalid,
   input  logic                o_tready,
   output logic                o_preamble
);

   localparam int unsigned HALF      = FFT_SIZE / 2;
   localparam logic [AW-1:0] CP_START  = AW'(HALF - CP_SIZE);
   localparam logic [AW-1:0] LAST_ADDR = AW'(HALF - 1);

   // Parameter sanity.
   if (FFT_SIZE < 4 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_fft
      $error("FFT_SIZE must be a power of two >= 4");
   end
   if (CP_SIZE < 1 || CP_SIZE > HALF) begin : g_bad_cp
      $error("CP_SIZE must be in 1..FFT_SIZE/2");
   end
   if (Q_MSB + 1 != SAMPLE_W / 2) begin : g_bad_pack
      $error("sample packing expects equal I and Q halves");
   end

   ins_state_t          state_q, state_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                tvalid_q, tvalid_d;
   logic                tlast_q, tlast_d;
   logic                pre_q, pre_d;
   logic [SAMPLE_W-1:0] pay_q, pay_d;
   logic                load;
   logic [SAMPLE_W-1:0] ram_rdata;

   // Output stage (and RAM read) may advance when empty or being drained.
   assign load = !tvalid_q || o_tready;

   preamble_ram #(
      .WIDTH (SAMPLE_W),
      .DEPTH (HALF)
   ) u_ram (
      .clk     (clk),
      .we_i    (cfg_we && (state_q == ST_IDLE)),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .re_i    (load),
      .raddr_i (addr_q),
      .rdata_o (ram_rdata)
   );

   // Next state, read address and output stage.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      pre_d    = pre_q;
      pay_d    = pay_q;

      if (load) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
         pre_d    = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // addr_q sits at CP_START here, so the IDLE cycle issues the first CP read.
            if (i_tvalid && !enable) begin
               state_d = ST_PAYLOAD;
            end else if (i_tvalid && load) begin
               tvalid_d = 1'b1;
               pre_d    = 1'b1;
               addr_d   = addr_q + AW'(1);
               state_d  = (addr_q == LAST_ADDR) ? ST_HALF0 : ST_CP;
            end
         end
         ST_CP: begin
            if (load) begin
               tvalid_d = 1'b1;
               pre_d    = 1'b1;
               addr_d   = addr_q + AW'(1);
               if (addr_q == LAST_ADDR) state_d = ST_HALF0;
            end
         end
         ST_HALF0: begin
            if (load) begin
               tvalid_d = 1'b1;
               pre_d    = 1'b1;
               addr_d   = addr_q + AW'(1);
               if (addr_q == LAST_ADDR) state_d = ST_HALF1;
            end
         end
         ST_HALF1: begin
            if (load) begin
               tvalid_d = 1'b1;
               pre_d    = 1'b1;
               addr_d   = addr_q + AW'(1);
               if (addr_q == LAST_ADDR) state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (load && i_tvalid) begin
               tvalid_d = 1'b1;
               tlast_d  = i_tlast;
               pay_d    = i_tdata;
               if (i_tlast) begin
                  state_d = ST_IDLE;
                  addr_d  = CP_START;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = CP_START;
         end
      endcase
   end

   // Control state; reset and clear both abandon any frame in flight.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q  <= ST_IDLE;
         addr_q   <= CP_START;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         pre_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         pre_q    <= pre_d;
      end
   end

   // Payload data register needs no reset.
   always_ff @(posedge clk) begin
      pay_q <= pay_d;
   end

   assign i_tready   = (state_q == ST_PAYLOAD) && load;
   assign cfg_busy   = (state_q != ST_IDLE);
   assign o_tvalid   = tvalid_q;
   assign o_tlast    = tlast_q;
   assign o_preamble = pre_q;
   assign o_tdata    = pre_q ? ram_rdata : pay_q;

endmodule
